// File: rtl/sdhci_dat_xfer_ctrl_pkg.sv
// sdhci_dat_xfer_ctrl_pkg: hardware-update record shared with the SDHCI register file
package sdhci_dat_xfer_ctrl_pkg;
  typedef struct packed {
    logic [15:0] d;
    logic        de;
  } writable_reg_t;
endpackage

// File: rtl/sdhci_dat_xfer_ctrl.sv
// sdhci_dat_xfer_ctrl: DAT transfer sequencer driving Present State bits, buffer enables and Block Count updates
module sdhci_dat_xfer_ctrl
  import sdhci_dat_xfer_ctrl_pkg::*;
#(
  parameter int BufWordBytes  = 4,
  parameter int MaxBlockBytes = 2048
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          sw_rst_dat_i,
  input  logic          start_i,
  input  logic          read_i,
  input  logic          multi_block_i,
  input  logic          block_count_enable_i,
  input  logic          auto_cmd12_enable_i,
  input  logic [15:0]   block_count_i,
  input  logic [11:0]   block_size_i,
  input  logic          buf_access_i,
  output logic          dat_block_start_o,
  input  logic          dat_block_done_i,
  input  logic          dat_error_i,
  output logic          auto_cmd12_req_o,
  input  logic          auto_cmd12_ack_i,
  output logic          read_transfer_active_o,
  output logic          write_transfer_active_o,
  output logic          buffer_read_enable_o,
  output logic          buffer_write_enable_o,
  output writable_reg_t block_count_hw_o
);
  localparam int WW = $clog2(MaxBlockBytes / BufWordBytes) + 1;
  typedef enum logic [2:0] {IDLE, WR_FILL, WR_SEND, RD_RECV, RD_DRAIN, CMD12} state_t;
  state_t state, state_d;
  logic rd, multi, bce, acmd12;
  logic [15:0] left, left_d;
  logic [WW-1:0] wpb, cnt, cnt_d, cnt_inc;
  logic start_q, start_d;
  writable_reg_t bc_d;
  logic accept, unbounded, word_done, more_now, more_after, cmd12_go;
  logic [12:0] bs_round;
  assign bs_round   = {1'b0, block_size_i} + 13'(BufWordBytes - 1);
  assign accept     = start_i && block_size_i != '0 &&
                      !(multi_block_i && block_count_enable_i && block_count_i == '0);
  assign unbounded  = multi && !bce;
  assign cnt_inc    = cnt + WW'(1);
  assign word_done  = buf_access_i && cnt_inc == wpb;
  assign more_now   = unbounded || left != '0;
  assign more_after = unbounded || left > 16'd1;
  assign cmd12_go   = acmd12 && multi;
  assign buffer_write_enable_o   = state == WR_FILL;
  assign buffer_read_enable_o    = state == RD_DRAIN;
  assign auto_cmd12_req_o        = state == CMD12;
  assign write_transfer_active_o = state == WR_FILL || state == WR_SEND || (state == CMD12 && !rd);
  assign read_transfer_active_o  = state == RD_RECV || state == RD_DRAIN || (state == CMD12 && rd);
  assign dat_block_start_o       = start_q;
  // next state, word/block counters and registered pulses; software DAT reset overrides everything
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    left_d  = left;
    start_d = 1'b0;
    bc_d    = '{d: block_count_hw_o.d, de: 1'b0};
    case (state)
      IDLE: if (accept) begin
        state_d = read_i ? RD_RECV : WR_FILL;
        start_d = read_i;
        cnt_d   = '0;
        left_d  = multi_block_i ? block_count_i : 16'd1;
      end
      WR_FILL: if (buf_access_i) begin
        cnt_d   = word_done ? '0 : cnt_inc;
        start_d = word_done;
        if (word_done) state_d = WR_SEND;
      end
      WR_SEND, RD_RECV: if (dat_error_i) state_d = IDLE;
      else if (dat_block_done_i) begin
        left_d = left - 16'd1;
        bc_d   = '{d: left - 16'd1, de: bce};
        if (state == RD_RECV) state_d = RD_DRAIN;
        else if (more_after) state_d = WR_FILL;
        else if (cmd12_go) state_d = CMD12;
        else state_d = IDLE;
      end
      RD_DRAIN: if (buf_access_i) begin
        cnt_d   = word_done ? '0 : cnt_inc;
        start_d = word_done && more_now;
        if (word_done && more_now) state_d = RD_RECV;
        else if (word_done && cmd12_go) state_d = CMD12;
        else if (word_done) state_d = IDLE;
      end
      CMD12: if (auto_cmd12_ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (sw_rst_dat_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      left_d  = '0;
      start_d = 1'b0;
      bc_d    = '0;
    end
  end
  // sequencer state, counters and registered pulse outputs
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state            <= IDLE;
      cnt              <= '0;
      left             <= '0;
      start_q          <= 1'b0;
      block_count_hw_o <= '0;
    end else begin
      state            <= state_d;
      cnt              <= cnt_d;
      left             <= left_d;
      start_q          <= start_d;
      block_count_hw_o <= bc_d;
    end
  // transfer configuration captured when a start is accepted
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      {rd, multi, bce, acmd12} <= '0;
      wpb                      <= '0;
    end else if (sw_rst_dat_i) begin
      {rd, multi, bce, acmd12} <= '0;
      wpb                      <= '0;
    end else if (state == IDLE && accept) begin
      {rd, multi, bce, acmd12} <= {read_i, multi_block_i, block_count_enable_i, auto_cmd12_enable_i};
      wpb                      <= WW'(bs_round / 13'(BufWordBytes));
    end
endmodule

// File: tb/tb_sdhci_dat_xfer_ctrl.sv
// tb_sdhci_dat_xfer_ctrl: directed vector table plus multi-cycle sequences for the DAT transfer sequencer
module tb_sdhci_dat_xfer_ctrl;
  import sdhci_dat_xfer_ctrl_pkg::*;
  logic clk_i = 0, rst_ni = 0, sw_rst_dat_i = 0, start_i = 0, read_i = 0, multi_block_i = 0;
  logic block_count_enable_i = 0, auto_cmd12_enable_i = 0, buf_access_i = 0;
  logic dat_block_done_i = 0, dat_error_i = 0, auto_cmd12_ack_i = 0;
  logic [15:0] block_count_i = 0;
  logic [11:0] block_size_i = 0;
  logic dat_block_start_o, auto_cmd12_req_o, read_transfer_active_o, write_transfer_active_o;
  logic buffer_read_enable_o, buffer_write_enable_o;
  writable_reg_t block_count_hw_o;
  logic [6:0] outs;
  int checks = 0, errors = 0;
  typedef struct {
    logic [4:0]  cfg;
    logic [15:0] bcnt;
    logic [11:0] bsize;
    logic [3:0]  ev;
    logic [6:0]  exp;
    logic [15:0] exp_d;
  } vec_t;
  vec_t vecs[$];
  sdhci_dat_xfer_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .sw_rst_dat_i(sw_rst_dat_i), .start_i(start_i),
    .read_i(read_i), .multi_block_i(multi_block_i), .block_count_enable_i(block_count_enable_i),
    .auto_cmd12_enable_i(auto_cmd12_enable_i), .block_count_i(block_count_i),
    .block_size_i(block_size_i), .buf_access_i(buf_access_i), .dat_block_start_o(dat_block_start_o),
    .dat_block_done_i(dat_block_done_i), .dat_error_i(dat_error_i),
    .auto_cmd12_req_o(auto_cmd12_req_o), .auto_cmd12_ack_i(auto_cmd12_ack_i),
    .read_transfer_active_o(read_transfer_active_o), .write_transfer_active_o(write_transfer_active_o),
    .buffer_read_enable_o(buffer_read_enable_o), .buffer_write_enable_o(buffer_write_enable_o),
    .block_count_hw_o(block_count_hw_o)
  );
  always #5 clk_i = ~clk_i;
  // observed outputs packed as {rta, wta, bre, bwe, dat_block_start, cmd12_req, bc_de}
  assign outs = {read_transfer_active_o, write_transfer_active_o, buffer_read_enable_o,
                 buffer_write_enable_o, dat_block_start_o, auto_cmd12_req_o, block_count_hw_o.de};
  function automatic vec_t mk(logic [4:0] cfg, logic [15:0] bcnt, logic [11:0] bsize,
                              logic [3:0] ev, logic [6:0] exp, logic [15:0] exp_d);
    vec_t x;
    x.cfg = cfg; x.bcnt = bcnt; x.bsize = bsize; x.ev = ev; x.exp = exp; x.exp_d = exp_d;
    return x;
  endfunction
  task automatic apply(input vec_t x);
    {start_i, read_i, multi_block_i, block_count_enable_i, auto_cmd12_enable_i} = x.cfg;
    block_count_i = x.bcnt;
    block_size_i  = x.bsize;
    {buf_access_i, dat_block_done_i, dat_error_i, auto_cmd12_ack_i} = x.ev;
  endtask
  task automatic idle_in();
    apply(mk(5'b0, 16'd0, 12'd0, 4'b0, 7'b0, 16'd0));
  endtask
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int n_en, n_st;
    // cfg = {start, read, multi, bce, acmd12}; ev = {buf_access, done, error, ack}
    vecs.push_back(mk(5'b10000, 16'd1, 12'd0, 4'b0000, 7'b0000000, 16'd0));
    vecs.push_back(mk(5'b11110, 16'd0, 12'd8, 4'b0000, 7'b0000000, 16'd0));
    vecs.push_back(mk(5'b00000, 16'd0, 12'd0, 4'b0000, 7'b0000000, 16'd0));
    vecs.push_back(mk(5'b11110, 16'd3, 12'd8, 4'b0000, 7'b1000100, 16'd0));
    vecs.push_back(mk(5'b00000, 16'd0, 12'd0, 4'b0000, 7'b1000000, 16'd0));
    vecs.push_back(mk(5'b00000, 16'd0, 12'd0, 4'b0100, 7'b1010001, 16'd2));
    vecs.push_back(mk(5'b00000, 16'd0, 12'd0, 4'b1000, 7'b1010000, 16'd0));
    vecs.push_back(mk(5'b00000, 16'd0, 12'd0, 4'b1000, 7'b1000100, 16'd0));
    vecs.push_back(mk(5'b00000, 16'd0, 12'd0, 4'b0100, 7'b1010001, 16'd1));
    vecs.push_back(mk(5'b00000, 16'd0, 12'd0, 4'b1000, 7'b1010000, 16'd0));
    vecs.push_back(mk(5'b00000, 16'd0, 12'd0, 4'b1000, 7'b1000100, 16'd0));
    vecs.push_back(mk(5'b00000, 16'd0, 12'd0, 4'b0100, 7'b1010001, 16'd0));
    vecs.push_back(mk(5'b00000, 16'd0, 12'd0, 4'b1000, 7'b1010000, 16'd0));
    vecs.push_back(mk(5'b00000, 16'd0, 12'd0, 4'b1000, 7'b0000000, 16'd0));
    vecs.push_back(mk(5'b00000, 16'd0, 12'd0, 4'b1000, 7'b0000000, 16'd0));
    vecs.push_back(mk(5'b10111, 16'd2, 12'd4, 4'b0000, 7'b0101000, 16'd0));
    vecs.push_back(mk(5'b11110, 16'd3, 12'd8, 4'b0000, 7'b0101000, 16'd0));
    vecs.push_back(mk(5'b00000, 16'd0, 12'd0, 4'b1000, 7'b0100100, 16'd0));
    vecs.push_back(mk(5'b00000, 16'd0, 12'd0, 4'b0100, 7'b0101001, 16'd1));
    vecs.push_back(mk(5'b00000, 16'd0, 12'd0, 4'b1000, 7'b0100100, 16'd0));
    vecs.push_back(mk(5'b00000, 16'd0, 12'd0, 4'b0100, 7'b0100011, 16'd0));
    vecs.push_back(mk(5'b00000, 16'd0, 12'd0, 4'b0000, 7'b0100010, 16'd0));
    vecs.push_back(mk(5'b00000, 16'd0, 12'd0, 4'b0001, 7'b0000000, 16'd0));
    vecs.push_back(mk(5'b11110, 16'd4, 12'd4, 4'b0000, 7'b1000100, 16'd0));
    vecs.push_back(mk(5'b00000, 16'd0, 12'd0, 4'b0100, 7'b1010001, 16'd3));
    vecs.push_back(mk(5'b00000, 16'd0, 12'd0, 4'b1000, 7'b1000100, 16'd0));
    vecs.push_back(mk(5'b00000, 16'd0, 12'd0, 4'b0110, 7'b0000000, 16'd0));
    vecs.push_back(mk(5'b00000, 16'd0, 12'd0, 4'b0000, 7'b0000000, 16'd0));
    cyc();
    cyc();
    chk("reset_outs", 16'(outs), 16'd0);
    chk("reset_bc_d", block_count_hw_o.d, 16'd0);
    rst_ni = 1;
    cyc();
    chk("post_reset_outs", 16'(outs), 16'd0);
    foreach (vecs[i]) begin
      apply(vecs[i]);
      cyc();
      chk($sformatf("vec%0d_outs", i), 16'(outs), 16'(vecs[i].exp));
      if (vecs[i].exp[0]) chk($sformatf("vec%0d_bc_d", i), block_count_hw_o.d, vecs[i].exp_d);
    end
    idle_in();
    apply(mk(5'b10000, 16'd7, 12'd512, 4'b0000, 7'b0, 16'd0));
    cyc();
    idle_in();
    chk("wr512_start", 16'(outs), 16'b0101000);
    n_en = 0;
    n_st = 0;
    for (int i = 0; i < 128; i++) begin
      n_en += int'(buffer_write_enable_o);
      buf_access_i = 1;
      cyc();
      n_st += int'(dat_block_start_o);
    end
    chk("wr512_enable_cycles", 16'(n_en), 16'd128);
    chk("wr512_block_starts", 16'(n_st), 16'd1);
    chk("wr512_send", 16'(outs), 16'b0100100);
    for (int j = 0; j < 3; j++) begin
      cyc();
      chk("wr512_send_ignore_access", 16'(outs), 16'b0100000);
    end
    buf_access_i = 0;
    dat_block_done_i = 1;
    cyc();
    dat_block_done_i = 0;
    chk("wr512_done", 16'(outs), 16'd0);
    apply(mk(5'b11110, 16'd2, 12'd24, 4'b0000, 7'b0, 16'd0));
    cyc();
    idle_in();
    chk("swrst_recv", 16'(outs), 16'b1000100);
    dat_block_done_i = 1;
    cyc();
    dat_block_done_i = 0;
    chk("swrst_drain", 16'(outs), 16'b1010001);
    chk("swrst_drain_d", block_count_hw_o.d, 16'd1);
    buf_access_i = 1;
    cyc();
    buf_access_i = 0;
    chk("swrst_pending", 16'(outs), 16'b1010000);
    sw_rst_dat_i = 1;
    cyc();
    sw_rst_dat_i = 0;
    chk("swrst_outs", 16'(outs), 16'd0);
    chk("swrst_bc_d", block_count_hw_o.d, 16'd0);
    cyc();
    chk("swrst_quiet", 16'(outs), 16'd0);
    apply(mk(5'b11000, 16'd9, 12'd5, 4'b0000, 7'b0, 16'd0));
    cyc();
    idle_in();
    chk("rd5_start", 16'(outs), 16'b1000100);
    dat_block_done_i = 1;
    cyc();
    dat_block_done_i = 0;
    chk("rd5_drain", 16'(outs), 16'b1010000);
    buf_access_i = 1;
    cyc();
    chk("rd5_word1", 16'(outs), 16'b1010000);
    cyc();
    buf_access_i = 0;
    chk("rd5_word2", 16'(outs), 16'd0);
    apply(mk(5'b10101, 16'd0, 12'd4, 4'b0000, 7'b0, 16'd0));
    cyc();
    idle_in();
    chk("unb_start", 16'(outs), 16'b0101000);
    for (int k = 0; k < 3; k++) begin
      buf_access_i = 1;
      cyc();
      buf_access_i = 0;
      chk("unb_send", 16'(outs), 16'b0100100);
      dat_block_done_i = 1;
      cyc();
      dat_block_done_i = 0;
      chk("unb_refill", 16'(outs), 16'b0101000);
    end
    sw_rst_dat_i = 1;
    cyc();
    sw_rst_dat_i = 0;
    chk("unb_swrst", 16'(outs), 16'd0);
    apply(mk(5'b10000, 16'd1, 12'd8, 4'b0000, 7'b0, 16'd0));
    cyc();
    idle_in();
    buf_access_i = 1;
    cyc();
    buf_access_i = 0;
    chk("arst_fill", 16'(outs), 16'b0101000);
    rst_ni = 0;
    #1;
    chk("arst_async", 16'(outs), 16'd0);
    cyc();
    rst_ni = 1;
    cyc();
    chk("arst_release", 16'(outs), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
